// File: rtl/maze_pkg.sv
// Shared constants for the maze movement controller: grid geometry, start/goal
// defaults, FSM state encoding and move direction encoding.
package maze_pkg;

    localparam int COORD_W     = 4;
    localparam int GRID_SIZE   = 1 << COORD_W;
    localparam int START_X     = 0;
    localparam int START_Y     = 0;
    localparam int GOAL_X      = GRID_SIZE - 1;
    localparam int GOAL_Y      = GRID_SIZE - 1;
    localparam int ACK_TIMEOUT = 255;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WIN  = 2'd2;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

endpackage

// File: rtl/maze_move_ctrl_rise_detect.sv
// Rising-edge detector: one register plus an AND gives a single-cycle pulse
// on each 0->1 transition of a synchronous input.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig_q <= 1'b0;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/maze_move_ctrl.sv
// Player movement controller: on each tick rise, picks a direction from the
// buttons, asks the maze map whether the target cell is a wall, then moves.
module maze_move_ctrl #(
    parameter int COORD_W     = maze_pkg::COORD_W,
    parameter int START_X     = maze_pkg::START_X,
    parameter int START_Y     = maze_pkg::START_Y,
    parameter int GOAL_X      = maze_pkg::GOAL_X,
    parameter int GOAL_Y      = maze_pkg::GOAL_Y,
    parameter int ACK_TIMEOUT = maze_pkg::ACK_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_in,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    output logic               wall_req,
    output logic [COORD_W-1:0] wall_x,
    output logic [COORD_W-1:0] wall_y,
    input  logic               wall_ack,
    input  logic               wall_hit,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               busy,
    output logic               win,
    output logic [15:0]        step_cnt,
    output logic               timeout_err
);

    import maze_pkg::*;

    localparam int                TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [COORD_W-1:0] C_MAX  = '1;
    localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);

    logic [1:0]         r_state;
    logic [COORD_W-1:0] r_pos_x;
    logic [COORD_W-1:0] r_pos_y;
    logic [COORD_W-1:0] r_wall_x;
    logic [COORD_W-1:0] r_wall_y;
    logic               r_wall_req;
    logic [15:0]        r_step_cnt;
    logic               r_timeout_err;
    logic [TO_W-1:0]    r_to_cnt;

    logic               w_tick_rise;
    logic               w_any_btn;
    dir_e               w_dir;
    logic               w_tgt_vld;
    logic [COORD_W-1:0] w_tgt_x;
    logic [COORD_W-1:0] w_tgt_y;
    logic               w_tgt_goal;

    rise_detect u_tick_rise (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (tick_in),
        .o_rise (w_tick_rise)
    );

    assign w_any_btn = btn_up | btn_down | btn_left | btn_right;

    always_comb begin
        w_dir = DIR_RIGHT;
        if (btn_up) begin
            w_dir = DIR_UP;
        end else if (btn_down) begin
            w_dir = DIR_DOWN;
        end else if (btn_left) begin
            w_dir = DIR_LEFT;
        end
    end

    // Edge of the grid blocks the move outright; no wrap-around.
    always_comb begin
        w_tgt_x   = r_pos_x;
        w_tgt_y   = r_pos_y;
        w_tgt_vld = 1'b0;
        case (w_dir)
            DIR_UP: begin
                w_tgt_y   = r_pos_y - C_ONE;
                w_tgt_vld = (r_pos_y != '0);
            end
            DIR_DOWN: begin
                w_tgt_y   = r_pos_y + C_ONE;
                w_tgt_vld = (r_pos_y != C_MAX);
            end
            DIR_LEFT: begin
                w_tgt_x   = r_pos_x - C_ONE;
                w_tgt_vld = (r_pos_x != '0);
            end
            default: begin
                w_tgt_x   = r_pos_x + C_ONE;
                w_tgt_vld = (r_pos_x != C_MAX);
            end
        endcase
    end

    // The held query target is the cell the player lands on when the map says free.
    assign w_tgt_goal = (r_wall_x == COORD_W'(GOAL_X)) && (r_wall_y == COORD_W'(GOAL_Y));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pos_x       <= COORD_W'(START_X);
            r_pos_y       <= COORD_W'(START_Y);
            r_wall_x      <= '0;
            r_wall_y      <= '0;
            r_wall_req    <= 1'b0;
            r_step_cnt    <= '0;
            r_timeout_err <= 1'b0;
            r_to_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_tick_rise && w_any_btn && w_tgt_vld) begin
                        r_state    <= ST_REQ;
                        r_wall_req <= 1'b1;
                        r_wall_x   <= w_tgt_x;
                        r_wall_y   <= w_tgt_y;
                        r_to_cnt   <= '0;
                    end
                end
                ST_REQ: begin
                    if (wall_ack) begin
                        r_wall_req <= 1'b0;
                        r_state    <= ST_IDLE;
                        if (!wall_hit) begin
                            r_pos_x <= r_wall_x;
                            r_pos_y <= r_wall_y;
                            if (r_step_cnt != 16'hFFFF) begin
                                r_step_cnt <= r_step_cnt + 16'd1;
                            end
                            if (w_tgt_goal) begin
                                r_state <= ST_WIN;
                            end
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_wall_req    <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                ST_WIN: begin
                    r_state <= ST_WIN;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wall_req    = r_wall_req;
    assign wall_x      = r_wall_x;
    assign wall_y      = r_wall_y;
    assign pos_x       = r_pos_x;
    assign pos_y       = r_pos_y;
    assign step_cnt    = r_step_cnt;
    assign timeout_err = r_timeout_err;
    assign busy        = (r_state == ST_REQ);
    assign win         = (r_state == ST_WIN);

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Self-checking bench for maze_move_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared each cycle to a behavioural model.
module tb_maze_move_ctrl;

    localparam int ACK_TO = 255;
    localparam int GRID   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_in;
    logic        btn_up, btn_down, btn_left, btn_right;
    logic        wall_ack, wall_hit;
    logic        wall_req, busy, win, timeout_err;
    logic [3:0]  wall_x, wall_y, pos_x, pos_y;
    logic [15:0] step_cnt;

    int n_checks   = 0;
    int n_fail     = 0;
    int req_cycles = 0;

    // Behavioural model: mode 0 = waiting for a move, 1 = query outstanding, 2 = won
    int m_mode, m_px, m_py, m_tx, m_ty, m_step, m_wait;
    bit m_to, m_tick_prev;

    maze_move_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .tick_in     (tick_in),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .wall_req    (wall_req),
        .wall_x      (wall_x),
        .wall_y      (wall_y),
        .wall_ack    (wall_ack),
        .wall_hit    (wall_hit),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .busy        (busy),
        .win         (win),
        .step_cnt    (step_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        int nx, ny;
        if (rst) begin
            m_mode = 0; m_px = 0; m_py = 0; m_tx = 0; m_ty = 0;
            m_step = 0; m_wait = 0; m_to = 1'b0; m_tick_prev = 1'b0;
            return;
        end
        if (m_mode == 0) begin
            if (tick_in && !m_tick_prev && (btn_up || btn_down || btn_left || btn_right)) begin
                nx = m_px;
                ny = m_py;
                if (btn_up)        ny = ny - 1;
                else if (btn_down) ny = ny + 1;
                else if (btn_left) nx = nx - 1;
                else               nx = nx + 1;
                if (nx >= 0 && nx < GRID && ny >= 0 && ny < GRID) begin
                    m_mode = 1; m_tx = nx; m_ty = ny; m_wait = 0;
                end
            end
        end else if (m_mode == 1) begin
            if (wall_ack) begin
                m_mode = 0;
                if (!wall_hit) begin
                    m_px = m_tx;
                    m_py = m_ty;
                    if (m_step < 65535) m_step = m_step + 1;
                    if (m_px == GRID - 1 && m_py == GRID - 1) m_mode = 2;
                end
            end else begin
                m_wait = m_wait + 1;
                if (m_wait == ACK_TO) begin
                    m_to   = 1'b1;
                    m_mode = 0;
                end
            end
        end
        m_tick_prev = tick_in;
    endtask

    // Model advances on every active edge; outputs are compared just after it.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (wall_req === 1'b1) req_cycles++;
            check("wall_req",    wall_req,    m_mode == 1);
            check("busy",        busy,        m_mode == 1);
            check("win",         win,         m_mode == 2);
            check("pos_x",       pos_x,       m_px);
            check("pos_y",       pos_y,       m_py);
            check("wall_x",      wall_x,      m_tx);
            check("wall_y",      wall_y,      m_ty);
            check("step_cnt",    step_cnt,    m_step);
            check("timeout_err", timeout_err, m_to);
        end
    end

    task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    endtask

    task automatic request(input logic u, input logic d, input logic l, input logic r);
        @(negedge clk);
        tick_in = 1'b1;
        set_btn(u, d, l, r);
        @(negedge clk);
        tick_in = 1'b0;
        set_btn(0, 0, 0, 0);
    endtask

    task automatic respond(input int delay, input logic hit);
        repeat (delay) @(negedge clk);
        wall_ack = 1'b1;
        wall_hit = hit;
        @(negedge clk);
        wall_ack = 1'b0;
        wall_hit = 1'b0;
    endtask

    task automatic move(input logic u, input logic d, input logic l, input logic r);
        request(u, d, l, r);
        respond(0, 1'b0);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tick_in = 1'b0; wall_ack = 1'b0; wall_hit = 1'b0;
        set_btn(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_pos_x",   pos_x, 0);
        check("rst_pos_y",   pos_y, 0);
        check("rst_wall_req", wall_req, 0);
        check("rst_wall_x",  wall_x, 0);
        check("rst_step",    step_cnt, 0);
        check("rst_busy",    busy, 0);
        check("rst_win",     win, 0);
        check("rst_timeout", timeout_err, 0);
        rst = 1'b0;

        // Move right, map answers after two waiting cycles.
        req_cycles = 0;
        request(0, 0, 0, 1);
        check("right_wall_x", wall_x, 1);
        check("right_wall_y", wall_y, 0);
        check("right_busy",   busy, 1);
        respond(2, 1'b0);
        check("right_req_cycles", req_cycles, 3);
        check("right_pos_x", pos_x, 1);
        check("right_pos_y", pos_y, 0);
        check("right_step",  step_cnt, 1);
        check("right_req_low", wall_req, 0);

        move(0, 0, 1, 0);
        check("left_pos_x", pos_x, 0);
        check("left_step",  step_cnt, 2);

        // Up from the top row is off the grid.
        req_cycles = 0;
        request(1, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("edge_req_cycles", req_cycles, 0);
        check("edge_pos_y", pos_y, 0);
        check("edge_busy",  busy, 0);

        repeat (5) move(0, 1, 0, 0);
        check("down5_pos_y", pos_y, 5);
        check("down5_step",  step_cnt, 7);

        // Up beats right; the map reports a wall.
        request(1, 0, 0, 1);
        check("prio_wall_x", wall_x, 0);
        check("prio_wall_y", wall_y, 4);
        respond(1, 1'b1);
        check("hit_pos_x", pos_x, 0);
        check("hit_pos_y", pos_y, 5);
        check("hit_step",  step_cnt, 7);

        repeat (15) move(0, 0, 0, 1);
        repeat (9) move(0, 1, 0, 0);
        check("pre_goal_x", pos_x, 15);
        check("pre_goal_y", pos_y, 14);
        move(0, 1, 0, 0);
        check("goal_pos_y", pos_y, 15);
        check("goal_win",   win, 1);
        check("goal_step",  step_cnt, 32);
        req_cycles = 0;
        request(0, 0, 1, 0);
        request(1, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("win_req_cycles", req_cycles, 0);
        check("win_sticky", win, 1);
        check("win_pos_x",  pos_x, 15);

        // Map never answers; a second tick during the query is dropped.
        pulse_rst();
        req_cycles = 0;
        request(0, 0, 0, 1);
        repeat (50) @(negedge clk);
        request(0, 1, 0, 0);
        repeat (260) @(negedge clk);
        check("to_flag",       timeout_err, 1);
        check("to_wall_req",   wall_req, 0);
        check("to_busy",       busy, 0);
        check("to_req_cycles", req_cycles, ACK_TO);
        check("to_pos_x",      pos_x, 0);
        check("to_pos_y",      pos_y, 0);
        move(0, 0, 0, 1);
        check("after_to_pos_x", pos_x, 1);
        check("after_to_flag",  timeout_err, 1);

        // Reset in the middle of a query, then a stale acknowledge.
        pulse_rst();
        request(0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wall_ack = 1'b1;
        @(negedge clk);
        wall_ack = 1'b0;
        @(negedge clk);
        check("abandon_pos_x",   pos_x, 0);
        check("abandon_step",    step_cnt, 0);
        check("abandon_wall_req", wall_req, 0);
        check("abandon_timeout", timeout_err, 0);

        // Randomized traffic, including ack-free stretches and stray acks.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 599) == 0);
            tick_in   = ($urandom_range(0, 2) == 0) ? ~tick_in : tick_in;
            btn_up    = ($urandom_range(0, 7) == 0);
            btn_down  = ($urandom_range(0, 2) == 0);
            btn_left  = ($urandom_range(0, 7) == 0);
            btn_right = ($urandom_range(0, 2) != 0);
            wall_hit  = ($urandom_range(0, 3) == 0);
            wall_ack  = ($urandom_range(0, 3) == 0);
            if ((i % 900) >= 500 && (i % 900) < 820) wall_ack = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        set_btn(0, 0, 0, 0);
        wall_ack = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
